// File: rtl/flow_isa_pkg.sv
// Shared instruction-set definitions for the datapath sequencer:
// opcode and load-source encodings, instruction field positions,
// sequencer state encoding and the decoded control bundle.
package flow_isa_pkg;

   // Opcodes, instruction bits [15:12]
   localparam logic [3:0] OP_NOP       = 4'h0;
   localparam logic [3:0] OP_ALU_FIRST = 4'h1;
   localparam logic [3:0] OP_ALU_LAST  = 4'h7;
   localparam logic [3:0] OP_ADDI      = 4'h8;
   localparam logic [3:0] OP_LOAD      = 4'h9;
   localparam logic [3:0] OP_STORE     = 4'hA;
   localparam logic [3:0] OP_PUSH      = 4'hB;
   localparam logic [3:0] OP_POP       = 4'hC;
   localparam logic [3:0] OP_SKZ       = 4'hD;
   localparam logic [3:0] OP_PLOT      = 4'hE;
   localparam logic [3:0] OP_HALT      = 4'hF;

   // Register-file write source
   localparam logic [1:0] LOAD_NONE = 2'b00;
   localparam logic [1:0] LOAD_ALU  = 2'b01;
   localparam logic [1:0] LOAD_MEM  = 2'b10;
   localparam logic [1:0] LOAD_STK  = 2'b11;

   // Instruction field positions
   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RD_MSB = 11;
   localparam int RD_LSB = 8;
   localparam int RA_MSB = 7;
   localparam int RA_LSB = 4;
   localparam int RB_MSB = 3;
   localparam int RB_LSB = 0;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_HALT   = 3'd4,
      ST_ERROR  = 3'd5
   } seq_state_t;

   // Every datapath control except the PC strobe
   typedef struct packed {
      logic [3:0]  alu_op;
      logic [3:0]  a_sel;
      logic [3:0]  b_sel;
      logic [15:0] a_alt;
      logic [15:0] b_alt;
      logic        a_src;
      logic        b_src;
      logic [3:0]  out_sel;
      logic [1:0]  load_src;
      logic        st_mem;
      logic        st_stk;
      logic [3:0]  color;
      logic [3:0]  coord;
      logic        plot;
   } ctrl_bundle_t;

   function automatic logic [3:0] field_op(input logic [15:0] w);
      return w[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational decode of the latched instruction into the full datapath
// control bundle as it must appear during EXEC. The sequencer decides in
// which cycles (if any) the bundle actually reaches the datapath.
module instruction_decoder
   import flow_isa_pkg::*;
(
   input  logic [15:0]  instr,
   output ctrl_bundle_t ctrl,
   output logic         is_halt,
   output logic         is_memop,
   output logic         is_skz
);

   logic [3:0] op_s;
   logic [3:0] rd_s;
   logic [3:0] ra_s;
   logic [3:0] rb_s;
   logic       is_alu_s;

   assign op_s     = field_op(instr);
   assign rd_s     = instr[RD_MSB:RD_LSB];
   assign ra_s     = instr[RA_MSB:RA_LSB];
   assign rb_s     = instr[RB_MSB:RB_LSB];
   assign is_alu_s = (op_s >= OP_ALU_FIRST) && (op_s <= OP_ALU_LAST);
   assign is_halt  = (op_s == OP_HALT);
   assign is_memop = (op_s >= OP_LOAD) && (op_s <= OP_POP);
   assign is_skz   = (op_s == OP_SKZ);

   // Map opcode and register fields onto the EXEC-cycle control bundle
   always_comb begin
      ctrl = '0;
      case (op_s)
         OP_ADDI: begin
            ctrl.alu_op   = 4'd1;
            ctrl.a_sel    = ra_s;
            ctrl.b_src    = 1'b1;
            ctrl.b_alt    = {12'h000, rb_s};
            ctrl.out_sel  = rd_s;
            ctrl.load_src = LOAD_ALU;
         end
         OP_LOAD: begin
            ctrl.a_sel    = ra_s;
            ctrl.out_sel  = rd_s;
            ctrl.load_src = LOAD_MEM;
         end
         OP_STORE: begin
            ctrl.a_sel  = ra_s;
            ctrl.b_sel  = rb_s;
            ctrl.st_mem = 1'b1;
         end
         OP_PUSH: begin
            ctrl.b_sel  = rb_s;
            ctrl.st_stk = 1'b1;
         end
         OP_POP: begin
            ctrl.out_sel  = rd_s;
            ctrl.load_src = LOAD_STK;
         end
         OP_PLOT: begin
            ctrl.color = rd_s;
            ctrl.coord = ra_s;
            ctrl.plot  = 1'b1;
         end
         default: begin
            // NOP, SKZ and HALT drive nothing; 1..7 are register ALU ops
            if (is_alu_s) begin
               ctrl.alu_op   = op_s;
               ctrl.a_sel    = ra_s;
               ctrl.b_sel    = rb_s;
               ctrl.out_sel  = rd_s;
               ctrl.load_src = LOAD_ALU;
            end else begin
               ctrl = '0;
            end
         end
      endcase
   end

endmodule

// File: rtl/datapath_sequencer.sv
// Fetch/decode/execute controller for the datapath. Latches the instruction
// at PC, decodes it and drives the datapath controls one instruction at a
// time; stops on HALT or on a datapath error. All outputs are registered
// from the next state so they line up with the state they belong to.
// Optional build macro: DATAPATH_SEQUENCER_TRACE_EN adds trace_valid /
// trace_instr and a simulation trace of each executed instruction.
module datapath_sequencer
   import flow_isa_pkg::*;
#(
   parameter int MEM_LATENCY = 1,
   parameter bit ERROR_CHECK = 1'b1
)(
   input  logic        clock,
   input  logic        resetn,
   input  logic        run,
   input  logic [15:0] current_instruction,
   input  logic [15:0] zeroflag,
   input  logic [15:0] signflag,
   input  logic [15:0] overflow,
   input  logic [15:0] errorbit,
   output logic        program_counter_increment,
   output logic [3:0]  alu_op,
   output logic [3:0]  alu_a_select,
   output logic [3:0]  alu_b_select,
   output logic [15:0] alu_a_altern,
   output logic [15:0] alu_b_altern,
   output logic        alu_a_source,
   output logic        alu_b_source,
   output logic [3:0]  alu_out_select,
   output logic [1:0]  alu_load_src,
   output logic        alu_store_to_mem,
   output logic        alu_store_to_stk,
   output logic [3:0]  vga_color_select,
   output logic [3:0]  vga_coord_select,
   output logic        vga_plot,
   output logic        halted,
   output logic        error
`ifdef DATAPATH_SEQUENCER_TRACE_EN
   ,
   output logic        trace_valid,
   output logic [15:0] trace_instr
`endif
);

   localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);

   seq_state_t   state_r, state_next_s;
   logic [15:0]  ir_r, ir_next_s;
   logic [3:0]   wait_cnt_r, wait_cnt_next_s;
   logic         skip_r, skip_next_s;
   logic         post_exec_r, post_exec_next_s;

   ctrl_bundle_t dec_ctrl_s;
   logic         dec_halt_s;
   logic         dec_memop_s;
   logic         dec_skz_s;

   ctrl_bundle_t ctrl_next_s, ctrl_r;
   logic         pc_inc_next_s, pc_inc_r;
   logic         halted_r, error_r;

   // Only bit 0 of each flag word is meaningful to the sequencer
   logic         unused_flags_s;
   assign unused_flags_s = ^{zeroflag[15:1], signflag, overflow, errorbit[15:1]};

   instruction_decoder u_decoder (
      .instr    (ir_r),
      .ctrl     (dec_ctrl_s),
      .is_halt  (dec_halt_s),
      .is_memop (dec_memop_s),
      .is_skz   (dec_skz_s)
   );

   // Next-state logic plus the control word for the state being entered
   always_comb begin
      state_next_s     = state_r;
      ir_next_s        = ir_r;
      wait_cnt_next_s  = wait_cnt_r;
      skip_next_s      = 1'b0;
      post_exec_next_s = 1'b0;
      ctrl_next_s      = '0;
      pc_inc_next_s    = 1'b0;

      case (state_r)
         ST_FETCH: begin
            if (ERROR_CHECK && post_exec_r && errorbit[0]) begin
               state_next_s = ST_ERROR;
            end else if (skip_r) begin
               // Skip cycle: the second PC bump happens here, nothing latched
               state_next_s = ST_FETCH;
            end else if (run) begin
               ir_next_s    = current_instruction;
               state_next_s = ST_DECODE;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (dec_halt_s) begin
               state_next_s = ST_HALT;
            end else if (dec_memop_s && (MEM_LATENCY > 0)) begin
               wait_cnt_next_s = 4'd0;
               state_next_s    = ST_WAIT;
            end else begin
               state_next_s = ST_EXEC;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r == WAIT_LAST) begin
               state_next_s = ST_EXEC;
            end else begin
               wait_cnt_next_s = wait_cnt_r + 4'd1;
            end
         end
         ST_EXEC: begin
            state_next_s     = ST_FETCH;
            post_exec_next_s = 1'b1;
            skip_next_s      = dec_skz_s && zeroflag[0];
         end
         ST_HALT:  state_next_s = ST_HALT;
         ST_ERROR: state_next_s = ST_ERROR;
         default:  state_next_s = ST_FETCH;
      endcase

      case (state_next_s)
         ST_EXEC: begin
            ctrl_next_s = dec_ctrl_s;
         end
         ST_WAIT: begin
            // Addresses/operands settle early; writes and strobes wait for EXEC
            ctrl_next_s          = dec_ctrl_s;
            ctrl_next_s.load_src = LOAD_NONE;
            ctrl_next_s.st_mem   = 1'b0;
            ctrl_next_s.st_stk   = 1'b0;
            ctrl_next_s.plot     = 1'b0;
         end
         default: begin
            ctrl_next_s = '0;
         end
      endcase

      pc_inc_next_s = (state_next_s == ST_EXEC) || skip_next_s;
   end

   // State, instruction register and registered control outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_FETCH;
         ir_r        <= 16'h0000;
         wait_cnt_r  <= 4'd0;
         skip_r      <= 1'b0;
         post_exec_r <= 1'b0;
         ctrl_r      <= '0;
         pc_inc_r    <= 1'b0;
         halted_r    <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         ir_r        <= ir_next_s;
         wait_cnt_r  <= wait_cnt_next_s;
         skip_r      <= skip_next_s;
         post_exec_r <= post_exec_next_s;
         ctrl_r      <= ctrl_next_s;
         pc_inc_r    <= pc_inc_next_s;
         halted_r    <= (state_next_s == ST_HALT) || (state_next_s == ST_ERROR);
         error_r     <= (state_next_s == ST_ERROR);
      end
   end

   assign program_counter_increment = pc_inc_r;
   assign alu_op           = ctrl_r.alu_op;
   assign alu_a_select     = ctrl_r.a_sel;
   assign alu_b_select     = ctrl_r.b_sel;
   assign alu_a_altern     = ctrl_r.a_alt;
   assign alu_b_altern     = ctrl_r.b_alt;
   assign alu_a_source     = ctrl_r.a_src;
   assign alu_b_source     = ctrl_r.b_src;
   assign alu_out_select   = ctrl_r.out_sel;
   assign alu_load_src     = ctrl_r.load_src;
   assign alu_store_to_mem = ctrl_r.st_mem;
   assign alu_store_to_stk = ctrl_r.st_stk;
   assign vga_color_select = ctrl_r.color;
   assign vga_coord_select = ctrl_r.coord;
   assign vga_plot         = ctrl_r.plot;
   assign halted           = halted_r;
   assign error            = error_r;

`ifdef DATAPATH_SEQUENCER_TRACE_EN
   logic        trace_valid_r;
   logic [31:0] pc_inc_count_r;

   // Trace strobe aligned with EXEC and running count of PC advances
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         trace_valid_r  <= 1'b0;
         pc_inc_count_r <= 32'd0;
      end else begin
         trace_valid_r  <= (state_next_s == ST_EXEC);
         pc_inc_count_r <= pc_inc_count_r + {31'd0, pc_inc_r};
      end
   end

   // Simulation-only log line for every executed instruction
   always_ff @(posedge clock) begin
      if (state_r == ST_EXEC) begin
         $display("trace: pc_inc_count=%0d ir=%h", pc_inc_count_r, ir_r);
      end else begin
      end
   end

   assign trace_valid = trace_valid_r;
   assign trace_instr = ir_r;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed test-plan cases plus
// randomized instructions, each checked cycle by cycle against expectations
// derived from the instruction-level rules (3 cycles per instruction, extra
// wait cycles for memory/stack ops, skip cycle after a taken SKZ).
module tb_datapath_sequencer;

   localparam int ML = 2;

   logic        clock = 1'b0;
   logic        resetn;
   logic        run;
   logic [15:0] current_instruction;
   logic [15:0] zeroflag;
   logic [15:0] signflag;
   logic [15:0] overflow;
   logic [15:0] errorbit;
   logic        program_counter_increment;
   logic [3:0]  alu_op;
   logic [3:0]  alu_a_select;
   logic [3:0]  alu_b_select;
   logic [15:0] alu_a_altern;
   logic [15:0] alu_b_altern;
   logic        alu_a_source;
   logic        alu_b_source;
   logic [3:0]  alu_out_select;
   logic [1:0]  alu_load_src;
   logic        alu_store_to_mem;
   logic        alu_store_to_stk;
   logic [3:0]  vga_color_select;
   logic [3:0]  vga_coord_select;
   logic        vga_plot;
   logic        halted;
   logic        error;

   int total = 0;
   int bad   = 0;

   logic [65:0] obs;
   localparam logic [65:0] V_ZERO = 66'd0;
   localparam logic [65:0] V_HALT = 66'd2;
   localparam logic [65:0] V_ERR  = 66'd3;
   localparam logic [65:0] V_SKIP = {1'b1, 65'd0};

   always #5 clock = ~clock;

   datapath_sequencer #(.MEM_LATENCY(ML), .ERROR_CHECK(1'b1)) dut (
      .clock                     (clock),
      .resetn                    (resetn),
      .run                       (run),
      .current_instruction       (current_instruction),
      .zeroflag                  (zeroflag),
      .signflag                  (signflag),
      .overflow                  (overflow),
      .errorbit                  (errorbit),
      .program_counter_increment (program_counter_increment),
      .alu_op                    (alu_op),
      .alu_a_select              (alu_a_select),
      .alu_b_select              (alu_b_select),
      .alu_a_altern              (alu_a_altern),
      .alu_b_altern              (alu_b_altern),
      .alu_a_source              (alu_a_source),
      .alu_b_source              (alu_b_source),
      .alu_out_select            (alu_out_select),
      .alu_load_src              (alu_load_src),
      .alu_store_to_mem          (alu_store_to_mem),
      .alu_store_to_stk          (alu_store_to_stk),
      .vga_color_select          (vga_color_select),
      .vga_coord_select          (vga_coord_select),
      .vga_plot                  (vga_plot),
      .halted                    (halted),
      .error                     (error)
   );

   assign obs = {program_counter_increment, alu_op, alu_a_select, alu_b_select,
                 alu_a_altern, alu_b_altern, alu_a_source, alu_b_source,
                 alu_out_select, alu_load_src, alu_store_to_mem, alu_store_to_stk,
                 vga_color_select, vga_coord_select, vga_plot, halted, error};

   task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Expected output word for an instruction: full EXEC controls when
   // exec=1, otherwise the held-operand view (no strobes, no write source)
   function automatic logic [65:0] ctrl_vec(input logic [15:0] w, input bit exec);
      logic [3:0]  op, rd, ra, rb, aop, asel, bsel, osel, col, crd;
      logic [15:0] balt;
      logic [1:0]  ld;
      logic        bsrc, stm, stk, plot;
      op = w[15:12]; rd = w[11:8]; ra = w[7:4]; rb = w[3:0];
      aop = 4'd0; asel = 4'd0; bsel = 4'd0; osel = 4'd0; col = 4'd0; crd = 4'd0;
      balt = 16'h0000; ld = 2'b00; bsrc = 1'b0; stm = 1'b0; stk = 1'b0; plot = 1'b0;
      if (op >= 4'd1 && op <= 4'd7) begin
         aop = op; asel = ra; bsel = rb; osel = rd; ld = 2'b01;
      end else if (op == 4'h8) begin
         aop = 4'd1; asel = ra; bsrc = 1'b1; balt = {12'h000, rb}; osel = rd; ld = 2'b01;
      end else if (op == 4'h9) begin
         asel = ra; osel = rd; ld = 2'b10;
      end else if (op == 4'hA) begin
         asel = ra; bsel = rb; stm = 1'b1;
      end else if (op == 4'hB) begin
         bsel = rb; stk = 1'b1;
      end else if (op == 4'hC) begin
         osel = rd; ld = 2'b11;
      end else if (op == 4'hE) begin
         col = rd; crd = ra; plot = 1'b1;
      end
      if (!exec) begin
         ld = 2'b00; stm = 1'b0; stk = 1'b0; plot = 1'b0;
      end
      return {exec, aop, asel, bsel, 16'h0000, balt, 1'b0, bsrc, osel, ld,
              stm, stk, col, crd, plot, 1'b0, 1'b0};
   endfunction

   // Runs one instruction starting in a FETCH cycle; leaves the bench in the
   // next FETCH cycle (or in the HALT/ERROR cycle)
   task automatic do_instr(input logic [15:0] w, input bit zf, input bit err);
      logic [3:0] op;
      op = w[15:12];
      check_eq("fetch", obs, V_ZERO);
      current_instruction = w; run = 1'b1; zeroflag = 16'h0000; errorbit = 16'h0000;
      tick();
      check_eq("decode", obs, V_ZERO);
      current_instruction = 16'($urandom); run = 1'($urandom);
      tick();
      if (op == 4'hF) begin
         check_eq("halt_enter", obs, V_HALT);
         return;
      end
      if (op >= 4'h9 && op <= 4'hC) begin
         for (int i = 0; i < ML; i++) begin
            check_eq("wait", obs, ctrl_vec(w, 1'b0));
            current_instruction = 16'($urandom); run = 1'($urandom);
            tick();
         end
      end
      check_eq("exec", obs, ctrl_vec(w, 1'b1));
      zeroflag = {15'($urandom), zf};
      errorbit = {15'($urandom), err};
      current_instruction = 16'($urandom); run = 1'($urandom);
      tick();
      if (op == 4'hD && zf) begin
         check_eq("skip", obs, V_SKIP);
         current_instruction = 16'hF000; run = 1'b1; errorbit = 16'h0000;
         tick();
      end
      if (err) begin
         check_eq("post_exec", obs, V_ZERO);
         current_instruction = 16'($urandom); run = 1'b1;
         tick();
         check_eq("error_enter", obs, V_ERR);
      end
   endtask

   task automatic do_reset();
      run = 1'b0; current_instruction = 16'h0000;
      zeroflag = 16'h0000; errorbit = 16'h0000;
      #2;
      resetn = 1'b0;
      #1;
      check_eq("rst_async", obs, V_ZERO);
      #4;
      resetn = 1'b1;
      tick();
      check_eq("rst_fetch", obs, V_ZERO);
   endtask

   initial begin
      logic [15:0] w;
      resetn = 1'b1; run = 1'b0; current_instruction = 16'h0000;
      zeroflag = 16'h0000; signflag = 16'h0000; overflow = 16'h0000; errorbit = 16'h0000;
      #1;
      do_reset();

      // Test-plan instructions
      do_instr(16'h8772, 1'b0, 1'b0);
      do_instr(16'h9340, 1'b0, 1'b0);
      do_instr(16'hD000, 1'b1, 1'b0);
      do_instr(16'hD000, 1'b0, 1'b0);
      do_instr(16'hE450, 1'b0, 1'b0);
      do_instr(16'hA123, 1'b0, 1'b0);
      do_instr(16'hB00C, 1'b0, 1'b0);
      do_instr(16'hC500, 1'b0, 1'b0);

      // Random instruction stream (HALT excluded to keep the stream running)
      for (int n = 0; n < 80; n++) begin
         w = 16'($urandom);
         if (w[15:12] == 4'hF) begin
            w[15:12] = 4'h0;
         end
         do_instr(w, 1'($urandom), 1'b0);
      end

      // Datapath error after an ALU op: sticky ERROR, run ignored
      do_instr(16'h3123, 1'b0, 1'b1);
      for (int n = 0; n < 3; n++) begin
         run = ~run;
         tick();
         check_eq("error_sticky", obs, V_ERR);
      end
      do_reset();

      // run=0 holds FETCH with no strobes
      run = 1'b0;
      current_instruction = 16'hE450;
      for (int n = 0; n < 4; n++) begin
         tick();
         check_eq("run_low_hold", obs, V_ZERO);
      end
      do_instr(16'h8772, 1'b0, 1'b0);

      // HALT is sticky until reset
      do_instr(16'hF000, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) begin
         run = ~run;
         tick();
         check_eq("halt_sticky", obs, V_HALT);
      end
      do_reset();
      do_instr(16'h8772, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
